// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential WIDTHxWIDTH unsigned multiplier built on one 2x2 digit multiplier
// One digit-pair partial product per clock; start/busy/done handshake.

module mult_seq_ctrl_mul2 (
    input  logic [1:0] x_i,
    input  logic [1:0] y_i,
    output logic [3:0] p_o
);
    always_comb begin
        p_o = {2'b00, (x_i[0] ? y_i : 2'b00)} + {1'b0, (x_i[1] ? y_i : 2'b00), 1'b0};
    end
endmodule

module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     product_q, product_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d;

    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [3:0]        pp;
    logic [CW:0]       ij_sum;
    logic [PW-1:0]     pp_sh;
    logic              j_wrap, last;

    // Current digits are brought down to bit 0 so the multiplier sees a fixed 2-bit slice.
    assign a_sh   = a_q >> {i_q, 1'b0};
    assign b_sh   = b_q >> {j_q, 1'b0};
    assign ij_sum = {1'b0, i_q} + {1'b0, j_q};
    assign pp_sh  = PW'(pp) << {ij_sum, 1'b0};
    assign j_wrap = (j_q == CW'(D - 1));
    assign last   = j_wrap && (i_q == CW'(D - 1));

    mult_seq_ctrl_mul2 u_mul2 (
        .x_i (a_sh[1:0]),
        .y_i (b_sh[1:0]),
        .p_o (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            i_q       <= i_d;
            j_q       <= j_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        i_d       = i_q;
        j_d       = j_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_q + pp_sh;
                if (last) begin
                    product_d = acc_q + pp_sh;
                    i_d       = '0;
                    j_d       = '0;
                    state_d   = S_DONE;
                end else if (j_wrap) begin
                    j_d = '0;
                    i_d = i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
endmodule
